selectie_traseu_param: RTL and testbench

Parametrised successor of the track-selection block. It synchronises the select and start buttons and applies a per-button lockout timer against bounce. It cycles through NUM_TRASEE tracks (0 = inactive), drives one-hot indicator LEDs, and runs a start countdown. After the countdown it asserts the MISCARE command to the motion controller.

---
 rtl/selectie_traseu_param_if.sv | 25 ++
 rtl/selectie_traseu_param.sv | 177 +++++++++++++++++
 tb/tb_selectie_traseu_param.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/selectie_traseu_param_if.sv
// Button inputs and track/countdown outputs of the track-selection block.
// Width of circuit and leds follows NUM_TRASEE.
interface selectie_traseu_param_if #(
    parameter int NUM_TRASEE = 3
);
    localparam int CW = $clog2(NUM_TRASEE + 1);

    logic                  buton_sel;
    logic                  buton_start;
    logic [CW-1:0]         circuit;
    logic [NUM_TRASEE-1:0] leds;
    logic                  numarare;
    logic [3:0]            secunde_ramase;
    logic                  miscare;

    modport master (
        output buton_sel, buton_start,
        input  circuit, leds, numarare, secunde_ramase, miscare
    );

    modport slave (
        input  buton_sel, buton_start,
        output circuit, leds, numarare, secunde_ramase, miscare
    );
endinterface

// File: rtl/selectie_traseu_param.sv
// Track selection with debounced buttons, start countdown and movement command.
// Optional LED blink during the countdown: define SELECTIE_TRASEU_BLINK_EN.
module selectie_traseu_param #(
    parameter int NUM_TRASEE  = 3,
    parameter int SEC_CYC     = 50000000,
    parameter int START_S     = 5,
    parameter int LOCKOUT_CYC = 50000000
`ifdef SELECTIE_TRASEU_BLINK_EN
    , parameter int BLINK_CYC = 12500000
`endif
) (
    input logic                   tact,
    input logic                   reset_n,
    selectie_traseu_param_if.slave bus
);
    localparam int CW = $clog2(NUM_TRASEE + 1);
    localparam int LW = $clog2(LOCKOUT_CYC + 1);
    localparam int SW = $clog2(SEC_CYC + 1);

    typedef enum logic [1:0] {IDLE, SELECTAT, NUMARARE, MISCARE} state_t;

    state_t                state;
    logic [CW-1:0]         circuit;
    logic [NUM_TRASEE-1:0] leds;
    logic                  numarare;
    logic [3:0]            secunde_ramase;
    logic                  miscare;
    logic [SW-1:0]         sub_cnt;

    // Index 0 = select button, index 1 = start button.
    logic [1:0]    raw, ff1, ff2, prev, acc;
    logic [LW-1:0] lock_cnt [2];

`ifdef SELECTIE_TRASEU_BLINK_EN
    localparam int BW = $clog2(BLINK_CYC + 1);
    logic [BW-1:0] blink_cnt;
    logic          blink_on;
`endif

    function automatic logic [NUM_TRASEE-1:0] decode(input logic [CW-1:0] c);
        logic [NUM_TRASEE-1:0] d;
        d = '0;
        for (int k = 1; k <= NUM_TRASEE; k++)
            if (c == CW'(k)) d[k-1] = 1'b1;
        return d;
    endfunction

    assign raw = {bus.buton_start, bus.buton_sel};

    always_comb begin
        acc = '0;
        for (int i = 0; i < 2; i++)
            acc[i] = ff2[i] & ~prev[i] & (lock_cnt[i] == '0);
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge tact or negedge reset_n) begin
        if (!reset_n) begin
            ff1  <= '0;
            ff2  <= '0;
            prev <= '0;
            for (int i = 0; i < 2; i++) lock_cnt[i] <= '0;
        end else begin
            ff1  <= raw;
            ff2  <= ff1;
            prev <= ff2;
            for (int i = 0; i < 2; i++) begin
                if (acc[i])
                    lock_cnt[i] <= LW'(LOCKOUT_CYC - 1);
                else if (lock_cnt[i] != '0)
                    lock_cnt[i] <= lock_cnt[i] - LW'(1);
            end
        end
    end

    always_ff @(posedge tact or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            circuit        <= '0;
            leds           <= '0;
            numarare       <= 1'b0;
            secunde_ramase <= '0;
            miscare        <= 1'b0;
            sub_cnt        <= '0;
`ifdef SELECTIE_TRASEU_BLINK_EN
            blink_cnt      <= '0;
            blink_on       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (acc[0]) begin
                        circuit <= CW'(1);
                        leds    <= decode(CW'(1));
                        state   <= SELECTAT;
                    end
                end
                SELECTAT: begin
                    // Start wins over a simultaneous select, which is then dropped.
                    if (acc[1]) begin
                        if (circuit != '0) begin
                            state          <= NUMARARE;
                            numarare       <= 1'b1;
                            secunde_ramase <= 4'(START_S);
                            sub_cnt        <= '0;
`ifdef SELECTIE_TRASEU_BLINK_EN
                            blink_cnt      <= '0;
                            blink_on       <= 1'b1;
`endif
                        end
                    end else if (acc[0]) begin
                        if (circuit == CW'(NUM_TRASEE)) begin
                            circuit <= '0;
                            leds    <= '0;
                            state   <= IDLE;
                        end else begin
                            circuit <= circuit + CW'(1);
                            leds    <= decode(circuit + CW'(1));
                        end
                    end
                end
                NUMARARE: begin
                    if (acc[0] || acc[1]) begin
                        state          <= SELECTAT;
                        numarare       <= 1'b0;
                        secunde_ramase <= '0;
                        sub_cnt        <= '0;
                        leds           <= decode(circuit);
`ifdef SELECTIE_TRASEU_BLINK_EN
                        blink_cnt      <= '0;
                        blink_on       <= 1'b0;
`endif
                    end else begin
`ifdef SELECTIE_TRASEU_BLINK_EN
                        if (blink_cnt == BW'(BLINK_CYC - 1)) begin
                            blink_cnt <= '0;
                            blink_on  <= ~blink_on;
                            leds      <= blink_on ? '0 : decode(circuit);
                        end else begin
                            blink_cnt <= blink_cnt + BW'(1);
                        end
`endif
                        if (sub_cnt == SW'(SEC_CYC - 1)) begin
                            sub_cnt        <= '0;
                            secunde_ramase <= secunde_ramase - 4'd1;
                            if (secunde_ramase == 4'd1) begin
                                state    <= MISCARE;
                                miscare  <= 1'b1;
                                numarare <= 1'b0;
                                leds     <= decode(circuit);
`ifdef SELECTIE_TRASEU_BLINK_EN
                                blink_cnt <= '0;
                                blink_on  <= 1'b0;
`endif
                            end
                        end else begin
                            sub_cnt <= sub_cnt + SW'(1);
                        end
                    end
                end
                MISCARE: begin
                    if (acc[1]) begin
                        state   <= SELECTAT;
                        miscare <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.circuit        = circuit;
    assign bus.leds           = leds;
    assign bus.numarare       = numarare;
    assign bus.secunde_ramase = secunde_ramase;
    assign bus.miscare        = miscare;
endmodule

// File: tb/tb_selectie_traseu_param.sv
// Directed bench for selectie_traseu_param: selection, debounce, countdown,
// abort, priority and asynchronous reset, with hand-computed expectations.
module tb_selectie_traseu_param;
    logic tact = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    selectie_traseu_param_if #(.NUM_TRASEE(3)) bus ();

    selectie_traseu_param #(
        .NUM_TRASEE (3),
        .SEC_CYC    (10),
        .START_S    (2),
        .LOCKOUT_CYC(4)
    ) dut (
        .tact   (tact),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 tact = ~tact;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge tact);
    endtask

    // Pins high across two rising edges; returns on the falling edge right after the
    // edge where the press takes effect (third rising edge after the pins went high).
    task automatic press(input logic s, input logic st);
        @(negedge tact);
        bus.buton_sel   = s;
        bus.buton_start = st;
        @(negedge tact);
        @(negedge tact);
        bus.buton_sel   = 1'b0;
        bus.buton_start = 1'b0;
        @(negedge tact);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_circuit"}, 32'(bus.circuit), 32'd0);
        check({tag, "_leds"},    32'(bus.leds), 32'd0);
        check({tag, "_numarare"}, 32'(bus.numarare), 32'd0);
        check({tag, "_sec"},     32'(bus.secunde_ramase), 32'd0);
        check({tag, "_miscare"}, 32'(bus.miscare), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] exp_leds [4];
        exp_leds[0] = 3'b001;
        exp_leds[1] = 3'b010;
        exp_leds[2] = 3'b100;
        exp_leds[3] = 3'b000;

        reset_n         = 1'b0;
        bus.buton_sel   = 1'b0;
        bus.buton_start = 1'b0;
        tick(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        tick(2);

        // Four clean select presses: 1, 2, 3, wrap to 0.
        for (int p = 0; p < 4; p++) begin
            press(1'b1, 1'b0);
            check("sel_circuit", 32'(bus.circuit), 32'((p + 1) % 4));
            check("sel_leds", 32'(bus.leds), 32'(exp_leds[p]));
            tick(7);
        end

        // Start while inactive is ignored (back in IDLE).
        press(1'b0, 1'b1);
        check("idle_start_numarare", 32'(bus.numarare), 32'd0);
        check("idle_start_circuit", 32'(bus.circuit), 32'd0);
        tick(6);

        // Bounce: high/low/high gives one increment; press 5 cycles later accepted.
        @(negedge tact) bus.buton_sel = 1'b1;
        @(negedge tact) bus.buton_sel = 1'b0;
        @(negedge tact) bus.buton_sel = 1'b1;
        @(negedge tact) bus.buton_sel = 1'b0;
        @(negedge tact);
        @(negedge tact);
        check("bounce_once", 32'(bus.circuit), 32'd1);
        bus.buton_sel = 1'b1;
        @(negedge tact);
        @(negedge tact) bus.buton_sel = 1'b0;
        @(negedge tact);
        check("after_lockout", 32'(bus.circuit), 32'd2);
        tick(6);

        // Countdown from circuit 2.
        press(1'b0, 1'b1);
        check("cd_numarare", 32'(bus.numarare), 32'd1);
        check("cd_sec_start", 32'(bus.secunde_ramase), 32'd2);
        check("cd_leds", 32'(bus.leds), 32'b010);
        tick(9);
        check("cd_sec_before", 32'(bus.secunde_ramase), 32'd2);
        tick(1);
        check("cd_sec_one", 32'(bus.secunde_ramase), 32'd1);
        tick(9);
        check("cd_miscare_early", 32'(bus.miscare), 32'd0);
        tick(1);
        check("cd_miscare", 32'(bus.miscare), 32'd1);
        check("cd_sec_end", 32'(bus.secunde_ramase), 32'd0);
        check("cd_numarare_end", 32'(bus.numarare), 32'd0);
        tick(6);

        // In MISCARE: select ignored, start returns to SELECTAT.
        press(1'b1, 1'b0);
        check("mis_sel_circuit", 32'(bus.circuit), 32'd2);
        check("mis_sel_miscare", 32'(bus.miscare), 32'd1);
        tick(6);
        press(1'b0, 1'b1);
        check("mis_stop_miscare", 32'(bus.miscare), 32'd0);
        check("mis_stop_circuit", 32'(bus.circuit), 32'd2);
        tick(6);
        press(1'b1, 1'b0);
        check("selectat_again", 32'(bus.circuit), 32'd3);
        tick(6);

        // Abort by select during the last second.
        press(1'b0, 1'b1);
        tick(12);
        check("abort_sec_one", 32'(bus.secunde_ramase), 32'd1);
        press(1'b1, 1'b0);
        check("abort_numarare", 32'(bus.numarare), 32'd0);
        check("abort_sec", 32'(bus.secunde_ramase), 32'd0);
        check("abort_circuit", 32'(bus.circuit), 32'd3);
        tick(20);
        check("abort_no_miscare", 32'(bus.miscare), 32'd0);

        // Simultaneous select and start with circuit 1: start wins.
        press(1'b1, 1'b0);
        check("wrap_to_idle", 32'(bus.circuit), 32'd0);
        tick(6);
        press(1'b1, 1'b0);
        tick(6);
        press(1'b1, 1'b1);
        check("both_numarare", 32'(bus.numarare), 32'd1);
        check("both_circuit", 32'(bus.circuit), 32'd1);
        check("both_sec", 32'(bus.secunde_ramase), 32'd2);
        check("both_leds", 32'(bus.leds), 32'b001);
        tick(5);

        // Asynchronous reset mid-countdown, checked before the next rising edge.
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge tact) reset_n = 1'b1;
        tick(12);
        check("post_reset_numarare", 32'(bus.numarare), 32'd0);
        check("post_reset_circuit", 32'(bus.circuit), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
